branch_predictor: RTL and testbench

- Fetch-side branch predictor for the RV32I core; the front end of the branch path, paired with the execute-stage branch comparator.
- Predicts direction and target for the fetch PC using a 2-bit bimodal history table (BHT) plus a direct-mapped branch target buffer (BTB).
- Trains on the resolved outcome (comparator taken result plus computed target) from execute.
- Flags mispredictions and supplies the corrected PC to the PC mux.

---
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side bimodal direction predictor with a direct-mapped BTB.
// Trains from execute, flags mispredicts and supplies the redirect PC.
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter int         TAG_BITS   = 8,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int N = 1 << INDEX_BITS;

  logic [1:0]          bht        [N];
  logic [N-1:0]        btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [N];
  logic [31:0]         btb_target [N];

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  hit;
  logic                  upd;
  logic                  dir_wrong;
  logic                  tgt_wrong;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[INDEX_BITS+2 +: TAG_BITS];
  assign ex_tag = ex_pc[INDEX_BITS+2 +: TAG_BITS];

  assign upd = ex_valid && ex_is_branch;

  // Lookup reads registered contents only; no bypass from the update.
  always_comb begin
    hit            = btb_valid[if_idx] &&
                     (btb_tag[if_idx] == if_tag);
    if_pred_taken  = hit && bht[if_idx][1];
    if_pred_target = if_pred_taken ? btb_target[if_idx]
                                   : if_pc + 32'd4;
  end

  // Resolution check against the prediction carried down the pipe.
  always_comb begin
    dir_wrong  = ex_taken != ex_pred_taken;
    tgt_wrong  = ex_taken && (ex_pred_target != ex_target);
    mispredict = upd && (dir_wrong || tgt_wrong);
    correct_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  end

  // Saturating 2-bit direction counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        bht[i] <= CNT_INIT;
      end
    end else if (upd) begin
      if (ex_taken && bht[ex_idx] != 2'b11) begin
        bht[ex_idx] <= bht[ex_idx] + 2'd1;
      end else if (!ex_taken && bht[ex_idx] != 2'b00) begin
        bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
    end
  end

  // BTB fill on taken branches; an alias is simply overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (upd && ex_taken) begin
      btb_valid[ex_idx]  <= 1'b1;
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= ex_target;
    end
  end

  // Branch and mispredict counters, free-running modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus
// randomized traffic against a table-level reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  // reference model: entry count 64, tag space 256
  int          m_cnt [64];
  bit          m_val [64];
  int unsigned m_tag [64];
  logic [31:0] m_tgt [64];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc),
    .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target),
    .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc),
    .ex_taken(ex_taken),
    .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .mispredict(mispredict),
    .correct_pc(correct_pc),
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  function automatic int unsigned m_idx(logic [31:0] pc);
    return (pc / 4) % 64;
  endfunction

  function automatic int unsigned m_tg(logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  function automatic bit m_ptaken(logic [31:0] pc);
    int unsigned i = m_idx(pc);
    return m_val[i] && m_tag[i] == m_tg(pc) && m_cnt[i] >= 2;
  endfunction

  function automatic logic [31:0] m_ptarget(logic [31:0] pc);
    if (m_ptaken(pc)) return m_tgt[m_idx(pc)];
    return pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    if (!(ex_valid && ex_is_branch)) return 1'b0;
    if (ex_taken != ex_pred_taken) return 1'b1;
    return ex_taken && ex_pred_target != ex_target;
  endfunction

  function automatic logic [31:0] m_cpc();
    return ex_taken ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_cnt[i] = 1;
      m_val[i] = 1'b0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic m_update();
    int unsigned i;
    if (!(ex_valid && ex_is_branch)) return;
    i = m_idx(ex_pc);
    if (m_mis()) m_mp++;
    m_br++;
    if (ex_taken) begin
      if (m_cnt[i] < 3) m_cnt[i]++;
      m_val[i] = 1'b1;
      m_tag[i] = m_tg(ex_pc);
      m_tgt[i] = ex_target;
    end else if (m_cnt[i] > 0) begin
      m_cnt[i]--;
    end
  endtask

  task automatic drive(input logic v, input logic b,
                       input logic [31:0] pc, input logic t,
                       input logic [31:0] tg, input logic pt,
                       input logic [31:0] ptg);
    ex_valid = v; ex_is_branch = b; ex_pc = pc;
    ex_taken = t; ex_target = tg;
    ex_pred_taken = pt; ex_pred_target = ptg;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset();
    else m_update();
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic t,
                       input logic [31:0] tg);
    drive(1, 1, pc, t, tg, m_ptaken(pc), m_ptarget(pc));
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_reset();
    repeat (3) tick();
    rst = 1'b0;
    if_pc = 32'h100;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_taken got %0h exp 0", if_pred_taken);
    end
    checks++;
    if (if_pred_target !== 32'h104) begin
      errors++;
      $display("FAIL reset_target got %h exp 00000104", if_pred_target);
    end
    checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d exp 0/0",
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_training();
    if_pc = 32'h200;
    drive(1, 1, 32'h200, 1, 32'h180, 0, 32'h204);
    checks++;
    if (mispredict !== 1'b1 || correct_pc !== 32'h180) begin
      errors++;
      $display("FAIL train_mis got %0h/%h exp 1/00000180",
               mispredict, correct_pc);
    end
    tick();
    idle();
    checks++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h180) begin
      errors++;
      $display("FAIL train_pred got %0h/%h exp 1/00000180",
               if_pred_taken, if_pred_target);
    end
    checks++;
    if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1) begin
      errors++;
      $display("FAIL train_stats got %0d/%0d exp 1/1",
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_saturation();
    if_pc = 32'h200;
    repeat (4) train(32'h200, 1, 32'h180);
    train(32'h200, 0, 32'h180);
    checks++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h180) begin
      errors++;
      $display("FAIL sat_hi got %0h/%h exp 1/00000180",
               if_pred_taken, if_pred_target);
    end
    train(32'h200, 0, 32'h180);
    checks++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h204) begin
      errors++;
      $display("FAIL sat_nt got %0h/%h exp 0/00000204",
               if_pred_taken, if_pred_target);
    end
    repeat (4) train(32'h200, 0, 32'h180);
    train(32'h200, 1, 32'h180);
    checks++;
    if (if_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL sat_lo got %0h exp 0", if_pred_taken);
    end
    train(32'h200, 1, 32'h180);
    checks++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h180) begin
      errors++;
      $display("FAIL sat_recover got %0h/%h exp 1/00000180",
               if_pred_taken, if_pred_target);
    end
  endtask

  task automatic test_aliasing();
    train(32'h200, 1, 32'h180);
    if_pc = 32'h300;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h304) begin
      errors++;
      $display("FAIL alias_miss got %0h/%h exp 0/00000304",
               if_pred_taken, if_pred_target);
    end
    train(32'h300, 1, 32'h500);
    checks++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h500) begin
      errors++;
      $display("FAIL alias_fill got %0h/%h exp 1/00000500",
               if_pred_taken, if_pred_target);
    end
    if_pc = 32'h200;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h204) begin
      errors++;
      $display("FAIL alias_evict got %0h/%h exp 0/00000204",
               if_pred_taken, if_pred_target);
    end
  endtask

  task automatic test_target_mismatch();
    logic [31:0] mp0;
    mp0 = m_mp;
    drive(1, 1, 32'h600, 1, 32'h340, 1, 32'h300);
    checks++;
    if (mispredict !== 1'b1 || correct_pc !== 32'h340) begin
      errors++;
      $display("FAIL tgt_mis got %0h/%h exp 1/00000340",
               mispredict, correct_pc);
    end
    tick();
    idle();
    checks++;
    if (stat_mispredicts !== mp0 + 32'd1) begin
      errors++;
      $display("FAIL tgt_stat got %0d exp %0d",
               stat_mispredicts, mp0 + 32'd1);
    end
    drive(1, 1, 32'h600, 1, 32'h340, 1, 32'h340);
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL tgt_ok got %0h exp 0", mispredict);
    end
    drive(1, 1, 32'h600, 0, 32'h340, 0, 32'h999);
    checks++;
    if (mispredict !== 1'b0 || correct_pc !== 32'h604) begin
      errors++;
      $display("FAIL nt_ok got %0h/%h exp 0/00000604",
               mispredict, correct_pc);
    end
    tick();
    idle();
  endtask

  task automatic test_gating();
    if_pc = 32'h700;
    drive(0, 1, 32'h700, 1, 32'h900, 0, 32'h0);
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL gate_mis got %0h exp 0", mispredict);
    end
    tick();
    tick();
    drive(1, 0, 32'h700, 1, 32'h900, 0, 32'h0);
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL gate_jal got %0h exp 0", mispredict);
    end
    tick();
    tick();
    idle();
    checks++;
    if (stat_branches !== m_br || stat_mispredicts !== m_mp) begin
      errors++;
      $display("FAIL gate_stats got %0d/%0d exp %0d/%0d",
               stat_branches, stat_mispredicts, m_br, m_mp);
    end
    checks++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h704) begin
      errors++;
      $display("FAIL gate_table got %0h/%h exp 0/00000704",
               if_pred_taken, if_pred_target);
    end
  endtask

  task automatic test_bypass();
    train(32'h800, 1, 32'h880);
    train(32'h800, 1, 32'h880);
    if_pc = 32'h800;
    drive(1, 1, 32'h800, 1, 32'h8c0, 1, 32'h880);
    checks++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h880) begin
      errors++;
      $display("FAIL bypass_old got %0h/%h exp 1/00000880",
               if_pred_taken, if_pred_target);
    end
    tick();
    idle();
    checks++;
    if (if_pred_target !== 32'h8c0) begin
      errors++;
      $display("FAIL bypass_new got %h exp 000008c0", if_pred_target);
    end
  endtask

  task automatic test_reset_mid_update();
    if_pc = 32'ha00;
    drive(1, 1, 32'ha00, 1, 32'hb00, 0, 32'h0);
    rst = 1'b1;
    m_reset();
    #1;
    checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL rst_async got %0d/%0d exp 0/0",
               stat_branches, stat_mispredicts);
    end
    tick();
    idle();
    rst = 1'b0;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'ha04) begin
      errors++;
      $display("FAIL rst_discard got %0h/%h exp 0/00000a04",
               if_pred_taken, if_pred_target);
    end
    checks++;
    if (stat_branches !== 32'd0) begin
      errors++;
      $display("FAIL rst_stat got %0d exp 0", stat_branches);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h1000 + 32'(4 * $urandom_range(0, 3))
                    + 32'(256 * $urandom_range(0, 2));
  endfunction

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] tg;
    logic        pt;
    logic [31:0] ptg;
    for (int n = 0; n < 400; n++) begin
      pc = rand_pc();
      tg = 32'h4000 + 32'(16 * $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) begin
        pt = m_ptaken(pc);
        ptg = m_ptarget(pc);
      end else begin
        pt = 1'($urandom_range(0, 1));
        ptg = 32'h4000 + 32'(16 * $urandom_range(0, 2));
      end
      if_pc = rand_pc();
      drive(1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 6) != 0),
            pc, 1'($urandom_range(0, 9) < 7), tg, pt, ptg);
      checks++;
      if (if_pred_taken !== m_ptaken(if_pc) ||
          if_pred_target !== m_ptarget(if_pc)) begin
        errors++;
        $display("FAIL rnd_pred pc=%h got %0h/%h exp %0h/%h", if_pc,
                 if_pred_taken, if_pred_target,
                 m_ptaken(if_pc), m_ptarget(if_pc));
      end
      checks++;
      if (mispredict !== m_mis() || correct_pc !== m_cpc()) begin
        errors++;
        $display("FAIL rnd_mis got %0h/%h exp %0h/%h",
                 mispredict, correct_pc, m_mis(), m_cpc());
      end
      tick();
      checks++;
      if (stat_branches !== m_br || stat_mispredicts !== m_mp) begin
        errors++;
        $display("FAIL rnd_stats got %0d/%0d exp %0d/%0d",
                 stat_branches, stat_mispredicts, m_br, m_mp);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_training();
    test_saturation();
    test_aliasing();
    test_target_mismatch();
    test_gating();
    test_bypass();
    test_reset_mid_update();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
